si_inst_queue: RTL and testbench
================================

Name: si_inst_queue

Overview:
- Decoupling instruction queue between the instruction-fetch stage and the decode stage of the single-issue core.
- Captures {pc, instruction} pairs from fetch, buffers up to DEPTH entries, and presents them in order to decode with valid/ready handshakes.
- Discards all buffered entries on a control-flow redirect (flush) so that decode never sees wrong-path instructions.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, 2..16
- INST_DW, 32, instruction width
- INST_AW, 32, PC width
- NOP_INST, 32'h0000_0013, value driven on deq_inst_o when the queue is empty (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush_i  in  1  redirect; clears queue contents this cycle
- enq_valid_i  in  1  fetch presents a valid pc/inst pair
- enq_ready_o  out  1  queue can accept an entry this cycle
- enq_pc_i  in  INST_AW  pc of the presented instruction
- enq_inst_i  in  INST_DW  presented instruction word
- deq_valid_o  out  1  head entry is valid
- deq_ready_i  in  1  decode consumes head this cycle
- deq_pc_o  out  INST_AW  pc of head entry
- deq_inst_o  out  INST_DW  instruction of head entry
- count_o  out  $clog2(DEPTH)+1  number of valid entries
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0

Behaviour:
- Reset (rst low, asynchronous): write and read pointers = 0, count = 0. While in reset: deq_valid_o = 0, empty_o = 1, full_o = 0, enq_ready_o = 0. Storage array is not reset.
- Reset release: enq_ready_o is 1 from the first cycle after rst rises.
- enq_ready_o = !full and rst high. It does not depend on deq_ready_i (no pass-through when full).
- Enqueue: occurs when enq_valid_i & enq_ready_o & !flush_i. The entry is written at wr_ptr, then wr_ptr increments modulo DEPTH.
- Dequeue: occurs when deq_valid_o & deq_ready_i & !flush_i. rd_ptr increments modulo DEPTH.
- deq_valid_o = !empty.
- deq_pc_o / deq_inst_o show the head entry when not empty. When empty: deq_pc_o = 0 and deq_inst_o = NOP_INST.
- Latency:
  - An entry enqueued in cycle N is visible on deq_* in cycle N+1.
  - There is no combinational enq-to-deq bypass.
- Count update:
  - Enqueue and dequeue in the same cycle: count unchanged.
  - Enqueue only: count+1.
  - Dequeue only: count-1.
- Pointers carry no extra wrap bit; full/empty are derived from count.
- Simultaneous enqueue and dequeue are legal at any occupancy except full, where enqueue is blocked.
- Flush has highest priority. In the flush cycle:
  - pointers and count go to 0 at the next edge;
  - any concurrent enqueue or dequeue is ignored;
  - the next cycle shows deq_valid_o = 0.
- After a flush, the first accepted entry is the one presented in the cycle after flush_i (the redirected pc from fetch).
- deq_ready_i while empty: no effect. enq_valid_i while full: no effect; fetch must hold the pair stable until accepted.
- Reset asserted mid-operation: all entries are discarded immediately and the reset values above apply.
- No arithmetic on pc/inst; data are stored verbatim.

Decomposition:
- Shared package si_pkg holds:
  - NOP_INST constant;
  - a packed typedef si_fetch_entry_t {pc[INST_AW-1:0], inst[INST_DW-1:0]}, reused by the decode stage;
  - a PTR_W helper localparam, $clog2(DEPTH).
- One natural sub-module, si_queue_ram: DEPTH x (INST_AW+INST_DW) register array with one write port and one asynchronous read port. Pointer and count control stays in si_inst_queue.

Test Plan:
- Reset then idle:
  - rst low → deq_valid_o=0, empty_o=1, count_o=0, deq_inst_o=32'h00000013, enq_ready_o=0.
  - rst high → enq_ready_o=1 next cycle.
- Single pass: enqueue pc=32'h8000_0000, inst=32'h00500093 at cycle N → deq_valid_o=1 at N+1 with the same pc/inst. Dequeuing at N+1 gives count_o=0 at N+2.
- Fill and wrap:
  - Enqueue 4 entries (pc 8000_0000..8000_000C), deq_ready_i=0 → full_o=1, enq_ready_o=0; a 5th offer is held off.
  - Then dequeue and enqueue concurrently for 8 cycles → strictly in-order pcs, count_o stays 3, pointers wrap correctly.
- Flush with traffic:
  - With count_o=3, assert flush_i together with enq_valid_i and deq_ready_i → next cycle count_o=0, deq_valid_o=0, neither entry consumed nor added.
  - Enqueue pc=32'h8000_0100 → it is the next head.
- Simultaneous enqueue/dequeue at count=1 → count stays 1 and the head advances to the newer entry.
- Asynchronous reset mid-burst: drop rst between clock edges with count_o=2 → count_o=0 and deq_valid_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/si_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
//   SI_DEPTH / SI_INST_AW / SI_INST_DW : default queue geometry
//   PTR_W                              : pointer width for the default depth
//   NOP_INST                           : canonical nop (addi x0,x0,0) shown when empty
//   si_fetch_entry_t                   : {pc, inst} pair, also consumed by decode
package si_pkg;

    localparam int unsigned SI_DEPTH   = 4;
    localparam int unsigned SI_INST_AW = 32;
    localparam int unsigned SI_INST_DW = 32;
    localparam int unsigned PTR_W      = $clog2(SI_DEPTH);

    localparam logic [SI_INST_DW-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [SI_INST_AW-1:0] pc;
        logic [SI_INST_DW-1:0] inst;
    } si_fetch_entry_t;

endpackage

// File: rtl/si_queue_ram.sv
// Register-array storage for the instruction queue.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : entry written at waddr_i
//   raddr_i : read index (asynchronous read)
//   rdata_o : entry stored at raddr_i
// Contents are intentionally not reset; validity is tracked by the controller.
module si_queue_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/si_inst_queue.sv
// Decoupling queue between instruction fetch and decode.
//   clk, rst (async, active-low)
//   flush_i                          : redirect, drops every buffered entry
//   enq_valid_i/enq_ready_o          : fetch handshake carrying enq_pc_i/enq_inst_i
//   deq_valid_o/deq_ready_i          : decode handshake carrying deq_pc_o/deq_inst_o
//   count_o, full_o, empty_o         : occupancy
// Entries appear at the output the cycle after they are accepted (no bypass).
module si_inst_queue
    import si_pkg::*;
#(
    parameter int unsigned         DEPTH    = SI_DEPTH,
    parameter int unsigned         INST_DW  = SI_INST_DW,
    parameter int unsigned         INST_AW  = SI_INST_AW,
    parameter logic [INST_DW-1:0]  NOP_INST = si_pkg::NOP_INST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [INST_AW-1:0]         enq_pc_i,
    input  logic [INST_DW-1:0]         enq_inst_i,
    output logic                       deq_valid_o,
    input  logic                       deq_ready_i,
    output logic [INST_AW-1:0]         deq_pc_o,
    output logic [INST_DW-1:0]         deq_inst_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = PW + 1;
    localparam int unsigned EW    = INST_AW + INST_DW;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Goes high on the first clock edge after reset is released.
    logic             init_done_q, init_done_d;

    logic             full, empty, do_enq, do_deq;
    logic [EW-1:0]    head_entry;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Flush masks both handshakes so nothing is consumed or added in that cycle.
    assign do_enq = enq_valid_i & enq_ready_o & ~flush_i;
    assign do_deq = deq_valid_o & deq_ready_i & ~flush_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        init_done_d = 1'b1;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: natural overflow gives the modulo wrap.
            if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_enq && !do_deq) count_d = count_q + 1'b1;
            if (!do_enq && do_deq) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            init_done_q <= init_done_d;
        end
    end

    si_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .we_i    (do_enq),
        .waddr_i (wr_ptr_q),
        .wdata_i ({enq_pc_i, enq_inst_i}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_entry)
    );

    // No pass-through when full: readiness ignores deq_ready_i.
    assign enq_ready_o = init_done_q & ~full;
    assign deq_valid_o = ~empty;
    assign deq_pc_o    = empty ? '0 : head_entry[EW-1:INST_DW];
    assign deq_inst_o  = empty ? NOP_INST : head_entry[INST_DW-1:0];
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;

endmodule

// File: tb/tb_si_inst_queue.sv
// Bench for si_inst_queue: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based reference model.
module tb_si_inst_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        enq_valid_i = 1'b0;
    logic        enq_ready_o;
    logic [31:0] enq_pc_i = '0;
    logic [31:0] enq_inst_i = '0;
    logic        deq_valid_o;
    logic        deq_ready_i = 1'b0;
    logic [31:0] deq_pc_o;
    logic [31:0] deq_inst_o;
    logic [2:0]  count_o;
    logic        full_o;
    logic        empty_o;

    si_inst_queue dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .enq_valid_i (enq_valid_i),
        .enq_ready_o (enq_ready_o),
        .enq_pc_i    (enq_pc_i),
        .enq_inst_i  (enq_inst_i),
        .deq_valid_o (deq_valid_o),
        .deq_ready_i (deq_ready_i),
        .deq_pc_o    (deq_pc_o),
        .deq_inst_o  (deq_inst_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t mq[$];      // reference contents, head at index 0
    bit   up = 0;     // reference: a clock edge has occurred since reset release
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor/scoreboard: compare outputs, then advance the reference model by
    // the handshakes that will take effect at the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            up = 0;
        end
        chk("enq_ready", enq_ready_o, up && mq.size() < DEPTH);
        chk("deq_valid", deq_valid_o, mq.size() != 0);
        chk("count", count_o, mq.size());
        chk("full", full_o, mq.size() == DEPTH);
        chk("empty", empty_o, mq.size() == 0);
        chk("deq_pc", deq_pc_o, (mq.size() != 0) ? mq[0].pc : 32'h0);
        chk("deq_inst", deq_inst_o, (mq.size() != 0) ? mq[0].inst : NOP);
        if (rst) begin
            if (flush_i) begin
                mq.delete();
            end else begin
                bit take_enq;
                bit take_deq;
                ent_t e;
                take_deq = (mq.size() != 0) && deq_ready_i;
                take_enq = enq_valid_i && up && (mq.size() < DEPTH);
                if (take_deq) void'(mq.pop_front());
                if (take_enq) begin
                    e.pc   = enq_pc_i;
                    e.inst = enq_inst_i;
                    mq.push_back(e);
                end
            end
            up = 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a pair and hold it until accepted (bounded).
    task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
        int n;
        bit ok;
        n = 0;
        enq_valid_i = 1'b1;
        enq_pc_i    = pc;
        enq_inst_i  = inst;
        do begin
            ok = enq_ready_o && !flush_i;
            cyc();
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL offer_timeout: pc %0h not accepted within 50 cycles", pc);
        end
        enq_valid_i = 1'b0;
    endtask

    initial begin
        bit acc;
        // Reset held for a few cycles; monitor checks reset-state outputs.
        repeat (3) cyc();
        rst = 1'b1;
        cyc();

        // Single pass.
        offer(32'h8000_0000, 32'h0050_0093);
        deq_ready_i = 1'b1;
        cyc();
        deq_ready_i = 1'b0;
        cyc();

        // Fill to full, then a held-off fifth offer.
        for (int i = 0; i < 4; i++) offer(32'h8000_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
        enq_valid_i = 1'b1;
        enq_pc_i    = 32'h8000_0010;
        enq_inst_i  = 32'h1000_0004;
        repeat (2) cyc();
        // Concurrent traffic through the wrap point.
        deq_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) offer(32'h8000_0010 + 32'(4 * i), 32'h1000_0004 + 32'(i));
        deq_ready_i = 1'b0;

        // Flush with count 3 alongside enqueue and dequeue requests.
        flush_i     = 1'b1;
        enq_valid_i = 1'b1;
        enq_pc_i    = 32'hdead_0000;
        deq_ready_i = 1'b1;
        cyc();
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
        offer(32'h8000_0100, 32'h0000_0537);

        // Simultaneous enqueue/dequeue at count 1.
        deq_ready_i = 1'b1;
        offer(32'h8000_0200, 32'h0010_0113);
        deq_ready_i = 1'b0;
        cyc();
        deq_ready_i = 1'b1;
        repeat (2) cyc();

        // Randomized traffic; pending offers are held until taken or flushed.
        acc = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!enq_valid_i || acc || flush_i) begin
                enq_valid_i = ($urandom_range(0, 3) != 0);
                enq_pc_i    = $urandom;
                enq_inst_i  = $urandom;
            end
            deq_ready_i = (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 39) == 0);
            acc = enq_valid_i && enq_ready_o && !flush_i;
            cyc();
        end
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
        flush_i     = 1'b1;
        cyc();
        flush_i     = 1'b0;

        // Asynchronous reset between edges with two entries queued.
        offer(32'h8000_0300, 32'h0000_0001);
        offer(32'h8000_0304, 32'h0000_0002);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_count", count_o, 0);
        chk("async_deq_valid", deq_valid_o, 0);
        chk("async_empty", empty_o, 1);
        chk("async_enq_ready", enq_ready_o, 0);
        chk("async_deq_inst", deq_inst_o, NOP);
        cyc();
        rst = 1'b1;
        cyc();
        offer(32'h8000_0400, 32'h0000_0003);
        deq_ready_i = 1'b1;
        repeat (2) cyc();
        deq_ready_i = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
